// File: rtl/registrador_universal.sv
// Universal register: parallel load, shift/rotate left/right, clear, with a word-completion counter.
// Optional registered parity output, built only when REGISTRADOR_PARITY_EN is defined.
module registrador_universal #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             Din_serie,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  output logic             Dout_serie_msb,
  output logic             Dout_serie_lsb,
  output logic [CW-1:0]    shift_count,
  output logic             word_done,
  output logic             parity
);
  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_CLR  = 3'b110,
    M_RSVD = 3'b111
  } mode_e;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] reg_q, reg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             is_shift;

  always_comb begin
    reg_d    = reg_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    is_shift = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        M_LOAD: begin reg_d = Din;                             cnt_d = '0; end
        M_SHL:  begin reg_d = {reg_q[WIDTH-2:0], Din_serie};   is_shift = 1'b1; end
        M_SHR:  begin reg_d = {Din_serie, reg_q[WIDTH-1:1]};   is_shift = 1'b1; end
        M_ROL:  begin reg_d = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]}; is_shift = 1'b1; end
        M_ROR:  begin reg_d = {reg_q[0], reg_q[WIDTH-1:1]};    is_shift = 1'b1; end
        M_CLR:  begin reg_d = '0;                              cnt_d = '0; end
        default: ;
      endcase
      // Counting is direction-agnostic: any mix of shift ops completes a word.
      if (is_shift) begin
        if (cnt_q == LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      reg_q  <= reg_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign Dout           = reg_q;
  assign Dout_serie_msb = reg_q[WIDTH-1];
  assign Dout_serie_lsb = reg_q[0];
  assign shift_count    = cnt_q;
  assign word_done      = done_q;

`ifdef REGISTRADOR_PARITY_EN
  // Parity is computed from the next value so it lines up with Dout.
  logic par_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) par_q <= 1'b0;
    else          par_q <= ^reg_d;
  end
  assign parity = par_q;
`else
  assign parity = 1'b0;
`endif

endmodule

// File: doc/registrador_universal.md
REGISTRADOR_UNIVERSAL -- requirements
Module: registrador_universal

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CW, default $clog2(WIDTH+1), meaning the shift-counter width (derived, not overridden).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  operation enable; 0 = hold all state.
REQ-006 mode  input  3  operation select, per REQ-012.
REQ-007 Din_serie  input  1  serial data in.
REQ-008 Din  input  WIDTH  parallel data in.
REQ-009 Dout  output  WIDTH  register contents.
REQ-010 Dout_serie_msb / Dout_serie_lsb  output  1 each  Dout[WIDTH-1] / Dout[0].
REQ-011 shift_count  output  CW  shifts since the last load, clear or wrap; word_done  output  1  one-cycle completion pulse; parity  output  1  per REQ-027.

Function
REQ-012 On each rising clk with en=1, the register SHALL update by mode:
- 000 hold
- 001 parallel load Din
- 010 shift left {reg[WIDTH-2:0], Din_serie}
- 011 shift right {Din_serie, reg[WIDTH-1:1]}
- 100 rotate left {reg[WIDTH-2:0], reg[WIDTH-1]}
- 101 rotate right {reg[0], reg[WIDTH-1:1]}
- 110 synchronous clear to 0
- 111 reserved, behaves as hold
REQ-013 With en=0, register, shift_count and word_done SHALL hold or deassert as follows: word_done SHALL be 0 and the other state SHALL be unchanged, regardless of mode.
REQ-014 Dout SHALL reflect the new register value in the cycle after the active edge (latency 1), with no combinational path from Din or Din_serie to Dout.
REQ-015 Modes 010-101 are "shift ops"; each enabled shift op SHALL increment shift_count by 1.
REQ-016 When an enabled shift op finds shift_count = WIDTH-1, shift_count SHALL wrap to 0 and word_done SHALL be 1 for exactly the following cycle.
REQ-017 Modes 001 and 110 SHALL reset shift_count to 0 and SHALL NOT assert word_done.
REQ-018 Modes 000 and 111 SHALL leave shift_count unchanged.
REQ-019 Direction changes mid-word (for example left then right) SHALL continue counting without resetting shift_count.
REQ-020 word_done SHALL be registered and SHALL be 0 in every cycle not covered by REQ-016.
REQ-021 Consecutive words of continuous shifting SHALL produce a word_done pulse every WIDTH enabled shift cycles, with no gap cycles.

Reset
REQ-022 reset_n=0 SHALL immediately, without waiting for clk, force the register to 0, shift_count to 0 and word_done to 0; Dout, both serial outputs and parity are then 0.
REQ-023 Reset asserted mid-word SHALL discard partial count; after release the next word SHALL need a full WIDTH shifts.
REQ-024 The first active edge after reset_n rises SHALL execute normally per mode.
REQ-025 Reset SHALL take priority over all inputs.

Configuration
REQ-026 The block SHALL use exactly one macro, REGISTRADOR_PARITY_EN.
REQ-027 With REGISTRADOR_PARITY_EN defined, parity SHALL be a register updated with the register contents so that parity = XOR of Dout, valid in the same cycle as Dout.
REQ-028 Without REGISTRADOR_PARITY_EN, the parity port SHALL remain and be tied to 0, and no parity logic SHALL be built.

Verification
REQ-029 Reset and load: WIDTH=8, reset_n low, then mode=001, Din=8'hA5 -> Dout=8'h00 during reset; next cycle Dout=8'hA5, shift_count=0, word_done=0.
REQ-030 Serial fill: 8 cycles of mode=010 with Din_serie=1,0,1,1,0,0,1,0 -> Dout=8'hB2 and word_done=1 exactly in the cycle after the 8th shift; shift_count=0.
REQ-031 Rotation: load 8'h81, then mode=100 for 1 cycle -> 8'h03; then mode=101 for 2 cycles -> 8'hC0; shift_count=3.
REQ-032 Enable gating: load 8'h0F, then mode=011 with en=0 for 5 cycles -> Dout stays 8'h0F and shift_count stays 0; then en=1 for 1 cycle with Din_serie=1 -> 8'h87.
REQ-033 Async reset mid-word: after 5 shifts, pulse reset_n low between edges -> Dout=0 and shift_count=0 before the next edge; then 7 shifts -> no word_done.
REQ-034 Parity, with the macro defined: load 8'h07 -> parity=1; shift left with Din_serie=1 -> 8'h0F, parity=0; without the macro, parity=0 throughout.
